// File: rtl/hazard_ctl.sv
// hazard_ctl
// Pipeline hazard controller for a classic five-stage in-order pipeline.
// It detects load-use hazards, taken branches, unconditional jumps and
// data-memory stalls, and drives the pipeline register write enables and
// bubble (flush) controls. A memory access that never completes is caught
// by a wait timer, and the block then halts with a sticky error until reset.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   if_id         instruction in the IF/ID register
//   id_ex         instruction in the ID/EX register
//   ex_mem        instruction in the EX/MEM register
//   br_taken      branch in EX resolved taken this cycle
//   mem_rdy       data memory completes the EX/MEM access this cycle
//   pc_we         PC write enable
//   if_id_we      IF/ID write enable
//   id_ex_we      ID/EX write enable
//   ex_mem_we     EX/MEM write enable
//   if_id_flush   load a bubble into IF/ID
//   id_ex_flush   load a bubble into ID/EX
//   mem_wb_flush  load a bubble into MEM/WB
//   mem_err       sticky memory-timeout error (registered)
//   state         FSM state, RUN=0 WAIT=1 HALT=2 (registered)
//   stall_cnt     saturating count of cycles with pc_we low (registered)

module hazard_ctl #(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_id,
  input  logic [31:0]      id_ex,
  input  logic [31:0]      ex_mem,
  input  logic             br_taken,
  input  logic             mem_rdy,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             mem_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  // The timer never drops below 8 bits so small WAIT_MAX values still
  // leave room to count the full wait without special casing.
  localparam int TIMER_W = ($clog2(WAIT_MAX + 1) > 8) ? $clog2(WAIT_MAX + 1) : 8;
  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(WAIT_MAX);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   stall_cnt_q;

  logic [5:0] if_op, id_op, mem_opcode;
  logic [4:0] if_rs, if_rt, id_rt;
  logic       mem_op, load_use, if_jump, if_uses_rt, mem_block;
  logic       unused_fields;

  function automatic logic is_load(input logic [5:0] op);
    return (op == 6'h20) || (op == 6'h21) || (op == 6'h23) ||
           (op == 6'h24) || (op == 6'h25);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return (op == 6'h04) || (op == 6'h05);
  endfunction

  function automatic logic is_jump(input logic [5:0] op);
    return (op == 6'h02) || (op == 6'h03);
  endfunction

  assign if_op      = if_id[31:26];
  assign if_rs      = if_id[25:21];
  assign if_rt      = if_id[20:16];
  assign id_op      = id_ex[31:26];
  assign id_rt      = id_ex[20:16];
  assign mem_opcode = ex_mem[31:26];

  // Immediate, offset and destination fields play no part in hazard detection.
  assign unused_fields = ^{if_id[15:0], id_ex[25:21], id_ex[15:0], ex_mem[25:0]};

  // Hazard decode. RT is only a source for R-type, store and branch formats;
  // for loads and immediates it names the destination, so matching it there
  // would create a false stall. Jumps carry a target, not register fields.
  always_comb begin
    mem_op     = is_load(mem_opcode) || is_store(mem_opcode);
    if_jump    = is_jump(if_op);
    if_uses_rt = (if_op == 6'h00) || is_store(if_op) || is_branch(if_op);
    load_use   = is_load(id_op) && (id_rt != 5'd0) && !if_jump &&
                 ((if_rs == id_rt) || (if_uses_rt && (if_rt == id_rt)));
    // Once waiting, the memory hold is driven purely by mem_rdy.
    mem_block  = !mem_rdy && (((state_q == S_RUN) && mem_op) || (state_q == S_WAIT));
  end

  // State register with the wait timer and the sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. The timer holds the number of WAIT cycles entered so
  // far; reaching WAIT_MAX with memory still busy ends in HALT.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    err_d   = err_q;
    case (state_q)
      S_RUN: begin
        if (mem_op && !mem_rdy) begin
          state_d = S_WAIT;
          timer_d = TIMER_W'(1);
        end else begin
          timer_d = '0;
        end
      end
      S_WAIT: begin
        if (mem_rdy) begin
          state_d = S_RUN;
          timer_d = '0;
        end else if (timer_q == TIMER_LIMIT) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_HALT: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = S_RUN;
        timer_d = '0;
      end
    endcase
  end

  // Output decode in priority order: memory hold, taken branch, load-use
  // bubble, jump. A branch seen during a memory hold is ignored because EX
  // keeps it and presents it again once memory releases.
  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    id_ex_we     = 1'b1;
    ex_mem_we    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (rst) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
    end else begin
      case (state_q)
        S_RUN, S_WAIT: begin
          if (mem_block) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            mem_wb_flush = 1'b1;
          end else if (br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (if_jump) begin
            if_id_flush = 1'b1;
          end
        end
        default: begin
          pc_we     = 1'b0;
          if_id_we  = 1'b0;
          id_ex_we  = 1'b0;
          ex_mem_we = 1'b0;
        end
      endcase
    end
  end

  // Stall cycle counter, saturating so long halts never read as short ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (!pc_we && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign state     = state_q;
  assign mem_err   = err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctl.sv
// tb_hazard_ctl
// Drives two hazard_ctl instances with identical inputs: one with default
// parameters and one with WAIT_MAX=4, CNT_W=4 so timeout and saturation
// are reachable quickly. Both are compared against a behavioural model
// every cycle, with extra directed checks on the key scenarios.

module tb_hazard_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_id, id_ex, ex_mem;
  logic        br_taken, mem_rdy;

  logic        pc_we_a, if_id_we_a, id_ex_we_a, ex_mem_we_a;
  logic        if_id_flush_a, id_ex_flush_a, mem_wb_flush_a, mem_err_a;
  logic [1:0]  state_a;
  logic [15:0] stall_cnt_a;

  logic        pc_we_b, if_id_we_b, id_ex_we_b, ex_mem_we_b;
  logic        if_id_flush_b, id_ex_flush_b, mem_wb_flush_b, mem_err_b;
  logic [1:0]  state_b;
  logic [3:0]  stall_cnt_b;

  logic [6:0]  outs_a, outs_b;

  int checks = 0;
  int errors = 0;

  // Model state per instance: 0 = default params, 1 = small params.
  int m_state[2];
  int m_waits[2];
  int m_stall[2];
  int m_err[2];
  int wmax[2] = '{255, 4};
  int cmax[2] = '{65535, 15};

  hazard_ctl dut_a (
    .clk(clk), .rst(rst), .if_id(if_id), .id_ex(id_ex), .ex_mem(ex_mem),
    .br_taken(br_taken), .mem_rdy(mem_rdy),
    .pc_we(pc_we_a), .if_id_we(if_id_we_a), .id_ex_we(id_ex_we_a),
    .ex_mem_we(ex_mem_we_a), .if_id_flush(if_id_flush_a),
    .id_ex_flush(id_ex_flush_a), .mem_wb_flush(mem_wb_flush_a),
    .mem_err(mem_err_a), .state(state_a), .stall_cnt(stall_cnt_a)
  );

  hazard_ctl #(.WAIT_MAX(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .if_id(if_id), .id_ex(id_ex), .ex_mem(ex_mem),
    .br_taken(br_taken), .mem_rdy(mem_rdy),
    .pc_we(pc_we_b), .if_id_we(if_id_we_b), .id_ex_we(id_ex_we_b),
    .ex_mem_we(ex_mem_we_b), .if_id_flush(if_id_flush_b),
    .id_ex_flush(id_ex_flush_b), .mem_wb_flush(mem_wb_flush_b),
    .mem_err(mem_err_b), .state(state_b), .stall_cnt(stall_cnt_b)
  );

  // Output vectors packed as {pc, if_id_we, id_ex_we, ex_mem_we,
  // if_id_flush, id_ex_flush, mem_wb_flush}.
  assign outs_a = {pc_we_a, if_id_we_a, id_ex_we_a, ex_mem_we_a,
                   if_id_flush_a, id_ex_flush_a, mem_wb_flush_a};
  assign outs_b = {pc_we_b, if_id_we_b, id_ex_we_b, ex_mem_we_b,
                   if_id_flush_b, id_ex_flush_b, mem_wb_flush_b};

  always #5 clk = ~clk;

  // Global time limit so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] time limit reached");
  end

  function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic bit op_load(input logic [5:0] op);
    return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  endfunction

  function automatic bit op_store(input logic [5:0] op);
    return op inside {6'h28, 6'h29, 6'h2B};
  endfunction

  function automatic bit op_branch(input logic [5:0] op);
    return op inside {6'h04, 6'h05};
  endfunction

  function automatic bit op_jump(input logic [5:0] op);
    return op inside {6'h02, 6'h03};
  endfunction

  // Load-use rule: a load's destination is read by the next instruction.
  function automatic bit model_load_use();
    logic [4:0] dst;
    bit         rt_is_src;
    dst = id_ex[20:16];
    if (!op_load(id_ex[31:26]) || dst == 5'd0 || op_jump(if_id[31:26])) return 1'b0;
    rt_is_src = (if_id[31:26] == 6'h00) || op_store(if_id[31:26]) || op_branch(if_id[31:26]);
    return (if_id[25:21] == dst) || (rt_is_src && if_id[20:16] == dst);
  endfunction

  // Expected output vector for a given model state and current inputs.
  function automatic logic [6:0] exp_out(input int st);
    if (rst) return 7'b0000000;
    if (st == 2) return 7'b0000000;
    if (!mem_rdy && (st == 1 || op_load(ex_mem[31:26]) || op_store(ex_mem[31:26])))
      return 7'b0000001;
    if (br_taken) return 7'b1111110;
    if (model_load_use()) return 7'b0011010;
    if (op_jump(if_id[31:26])) return 7'b1111100;
    return 7'b1111000;
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [5:0] op;
    case ($urandom_range(0, 11))
      0: op = 6'h00;  1: op = 6'h08;  2: op = 6'h20;  3: op = 6'h23;
      4: op = 6'h25;  5: op = 6'h2B;  6: op = 6'h28;  7: op = 6'h04;
      8: op = 6'h05;  9: op = 6'h02;  10: op = 6'h03;
      default: op = 6'($urandom_range(0, 63));
    endcase
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0;
      m_waits[k] = 0;
      m_stall[k] = 0;
      m_err[k]   = 0;
    end
  endtask

  task automatic modelUpdate();
    logic [6:0] o;
    if (rst) begin
      modelReset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      o = exp_out(m_state[k]);
      if (!o[6] && m_stall[k] < cmax[k]) m_stall[k]++;
      case (m_state[k])
        0: if ((op_load(ex_mem[31:26]) || op_store(ex_mem[31:26])) && !mem_rdy) begin
             m_state[k] = 1;
             m_waits[k] = 1;
           end
        1: if (mem_rdy) begin
             m_state[k] = 0;
             m_waits[k] = 0;
           end else if (m_waits[k] == wmax[k]) begin
             m_state[k] = 2;
             m_err[k]   = 1;
           end else begin
             m_waits[k]++;
           end
        default: ;
      endcase
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic br, input logic rdy);
    if_id    = a;
    id_ex    = b;
    ex_mem   = c;
    br_taken = br;
    mem_rdy  = rdy;
    #1;
  endtask

  task automatic checkOutput();
    chk("outs_a",  {25'd0, outs_a}, {25'd0, exp_out(m_state[0])});
    chk("state_a", 32'(state_a), 32'(m_state[0]));
    chk("err_a",   32'(mem_err_a), 32'(m_err[0]));
    chk("cnt_a",   32'(stall_cnt_a), 32'(m_stall[0]));
    chk("outs_b",  {25'd0, outs_b}, {25'd0, exp_out(m_state[1])});
    chk("state_b", 32'(state_b), 32'(m_state[1]));
    chk("err_b",   32'(mem_err_b), 32'(m_err[1]));
    chk("cnt_b",   32'(stall_cnt_b), 32'(m_stall[1]));
  endtask

  task automatic clockStep();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] lw2, add324, sw, lw;
    int          s0;
    lw2    = ins(6'h23, 5'd1, 5'd2, 5'd0);
    add324 = ins(6'h00, 5'd2, 5'd4, 5'd3);
    sw     = ins(6'h2B, 5'd1, 5'd2, 5'd0);
    lw     = ins(6'h23, 5'd1, 5'd5, 5'd0);

    // Reset state
    rst = 1'b1;
    modelReset();
    applyStimulus(add324, lw2, 32'd0, 1'b1, 1'b1);
    #1;
    checkOutput();
    chk("reset_outs", {25'd0, outs_a}, 32'd0);
    chk("reset_state", 32'(state_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Load-use: one bubble, then default outputs
    applyStimulus(add324, lw2, 32'd0, 1'b0, 1'b1);
    checkOutput();
    chk("lu_pc_we", 32'(pc_we_a), 32'd0);
    chk("lu_if_id_we", 32'(if_id_we_a), 32'd0);
    chk("lu_id_ex_flush", 32'(id_ex_flush_a), 32'd1);
    clockStep();
    applyStimulus(add324, 32'd0, 32'd0, 1'b0, 1'b1);
    checkOutput();
    chk("lu_next_default", {25'd0, outs_a}, 32'b1111000);
    chk("lu_stall_cnt", 32'(stall_cnt_a), 32'd1);
    clockStep();

    // No false stalls
    applyStimulus(ins(6'h00, 5'd0, 5'd7, 5'd1), ins(6'h23, 5'd1, 5'd0, 5'd0), 32'd0, 1'b0, 1'b1);
    checkOutput();
    chk("nofalse_lw0", {25'd0, outs_a}, 32'b1111000);
    clockStep();
    applyStimulus(ins(6'h08, 5'd5, 5'd3, 5'd0), lw2, 32'd0, 1'b0, 1'b1);
    checkOutput();
    chk("nofalse_addi", {25'd0, outs_a}, 32'b1111000);
    clockStep();
    applyStimulus(ins(6'h08, 5'd5, 5'd2, 5'd0), lw2, 32'd0, 1'b0, 1'b1);
    checkOutput();
    chk("nofalse_addi_rt_dst", {25'd0, outs_a}, 32'b1111000);
    chk("nofalse_cnt", 32'(stall_cnt_a), 32'd1);
    clockStep();

    // Branch outranks load-use; jump flushes IF/ID without a stall
    applyStimulus(add324, lw2, 32'd0, 1'b1, 1'b1);
    checkOutput();
    chk("br_priority", {25'd0, outs_a}, 32'b1111110);
    clockStep();
    applyStimulus(ins(6'h02, 5'd2, 5'd2, 5'd0), lw2, 32'd0, 1'b0, 1'b1);
    checkOutput();
    chk("jump_flush", {25'd0, outs_a}, 32'b1111100);
    clockStep();

    // Store and branch read RT, so they do stall
    applyStimulus(ins(6'h2B, 5'd9, 5'd2, 5'd0), lw2, 32'd0, 1'b0, 1'b1);
    checkOutput();
    chk("lu_store_rt", {25'd0, outs_a}, 32'b0011010);
    clockStep();
    applyStimulus(ins(6'h04, 5'd9, 5'd2, 5'd0), lw2, 32'd0, 1'b0, 1'b1);
    checkOutput();
    chk("lu_branch_rt", {25'd0, outs_a}, 32'b0011010);
    clockStep();

    // Memory wait of three cycles with a branch ignored while held
    s0 = m_stall[0];
    applyStimulus(32'd0, 32'd0, sw, 1'b0, 1'b0);
    checkOutput();
    chk("mw1_state", 32'(state_a), 32'd0);
    chk("mw1_outs", {25'd0, outs_a}, 32'b0000001);
    clockStep();
    applyStimulus(32'd0, 32'd0, sw, 1'b1, 1'b0);
    checkOutput();
    chk("mw2_state", 32'(state_a), 32'd1);
    chk("mw2_br_ignored", {25'd0, outs_a}, 32'b0000001);
    clockStep();
    applyStimulus(32'd0, 32'd0, sw, 1'b0, 1'b0);
    checkOutput();
    chk("mw3_state", 32'(state_a), 32'd1);
    clockStep();
    applyStimulus(32'd0, 32'd0, sw, 1'b1, 1'b1);
    checkOutput();
    chk("mw4_state", 32'(state_a), 32'd1);
    chk("mw4_br_replay", {25'd0, outs_a}, 32'b1111110);
    clockStep();
    applyStimulus(32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    checkOutput();
    chk("mw5_state", 32'(state_a), 32'd0);
    chk("mw5_stall_delta", 32'(stall_cnt_a), 32'(s0 + 3));
    clockStep();

    // Timeout on the WAIT_MAX=4 instance: four WAIT cycles, then HALT
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(32'd0, 32'd0, lw, 1'b0, 1'b0);
      checkOutput();
      chk("to_state_b", 32'(state_b), (i == 1) ? 32'd0 : ((i <= 5) ? 32'd1 : 32'd2));
      chk("to_err_b", 32'(mem_err_b), (i >= 6) ? 32'd1 : 32'd0);
      clockStep();
    end
    applyStimulus(32'd0, 32'd0, lw, 1'b0, 1'b1);
    chk("halt_held_outs_b", {25'd0, outs_b}, 32'd0);
    chk("halt_held_state_b", 32'(state_b), 32'd2);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput();
    chk("rst_async_state_b", 32'(state_b), 32'd0);
    chk("rst_async_err_b", 32'(mem_err_b), 32'd0);
    clockStep();
    rst = 1'b0;

    // Saturation: 20 stall cycles into a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      applyStimulus(add324, lw2, 32'd0, 1'b0, 1'b1);
      checkOutput();
      clockStep();
    end
    applyStimulus(32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("sat_cnt_b", 32'(stall_cnt_b), 32'd15);
    chk("sat_cnt_a", 32'(stall_cnt_a), 32'd20);
    clockStep();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (rst) modelReset();
      applyStimulus(rand_ins(), rand_ins(), rand_ins(),
                    1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) > 2));
      checkOutput();
      clockStep();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
